adc_capture_ctl: RTL and testbench



---
 rtl/adc_capture_pkg.sv | 21 ++
 rtl/adc_trig_det.sv | 48 ++++
 rtl/adc_capture_ctl.sv | 152 +++++++++++++++
 tb/tb_adc_capture_ctl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared constants for the ADC snapshot capture sequencer: state encoding,
// trigger mode codes and a small state-decode helper.
package adc_capture_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] POST = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [1:0] MODE_IMM  = 2'd0;
  localparam logic [1:0] MODE_RISE = 2'd1;
  localparam logic [1:0] MODE_FALL = 2'd2;
  localparam logic [1:0] MODE_EXT  = 2'd3;

  // States in which samples are written to the snapshot RAM.
  function automatic logic is_capturing(input logic [2:0] st);
    return (st == PRE) || (st == WAIT) || (st == POST);
  endfunction

endpackage

// File: rtl/adc_trig_det.sv
// Trigger detector: tracks the previous sample and evaluates the selected
// trigger condition; hit is combinational and only asserted with in_v.
module adc_trig_det
  import adc_capture_pkg::*;
#(
  parameter int isz = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_v,
  input  logic [isz-1:0] in_dat,
  input  logic [1:0]     mode,
  input  logic [isz-1:0] thresh,
  input  logic           ext_trig,
  output logic           hit
);

  logic signed [isz-1:0] prev_reg;
  logic signed [isz-1:0] cur_s;
  logic signed [isz-1:0] thr_s;
  logic                  cond;

  assign cur_s = $signed(in_dat);
  assign thr_s = $signed(thresh);

  // prev follows every strobed sample regardless of sequencer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= '0;
    end else if (in_v) begin
      prev_reg <= cur_s;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (mode)
      MODE_IMM:  cond = 1'b1;
      MODE_RISE: cond = (prev_reg < thr_s) && (cur_s >= thr_s);
      MODE_FALL: cond = (prev_reg > thr_s) && (cur_s <= thr_s);
      MODE_EXT:  cond = ext_trig;
      default:   cond = 1'b0;
    endcase
  end

  assign hit = in_v & cond;

endmodule

// File: rtl/adc_capture_ctl.sv
// Capture sequencer for the ADC snapshot RAM: pre-trigger fill, circular
// wait for a trigger, post-trigger fill, with a fully registered write port.
module adc_capture_ctl
  import adc_capture_pkg::*;
#(
  parameter int isz = 10,
  parameter int asz = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           arm,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic [isz-1:0] thresh,
  input  logic [asz-1:0] pretrig,
  input  logic           ext_trig,
  input  logic           in_v,
  input  logic [isz-1:0] in_dat,
  input  logic           in_otr,
  output logic           wen,
  output logic [asz-1:0] waddr,
  output logic [isz:0]   wdat,
  output logic           busy,
  output logic           done,
  output logic [asz-1:0] trig_addr
);

  logic [2:0]     state_reg, state_next;
  logic [asz-1:0] ptr_reg, ptr_next;
  logic [asz-1:0] cnt_reg, cnt_next;
  logic [asz-1:0] pre_reg, pre_next;
  logic [asz-1:0] trig_addr_reg, trig_addr_next;
  logic           wen_reg;
  logic [asz-1:0] waddr_reg;
  logic [isz:0]   wdat_reg;

  logic           hit;
  logic           capturing;
  logic           wr_go;
  logic [asz-1:0] post_cnt;

  adc_trig_det #(
    .isz(isz)
  ) u_trig_det (
    .clk     (clk),
    .reset   (reset),
    .in_v    (in_v),
    .in_dat  (in_dat),
    .mode    (mode),
    .thresh  (thresh),
    .ext_trig(ext_trig),
    .hit     (hit)
  );

  assign capturing = is_capturing(state_reg);
  // A sample arriving with abort is dropped; the capture is being torn down.
  assign wr_go     = capturing & in_v & ~abort;
  // 2^asz-1-pretrig samples follow the trigger sample.
  assign post_cnt  = ~pre_reg;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    pre_next       = pre_reg;
    trig_addr_next = trig_addr_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (arm && !abort) begin
          ptr_next   = '0;
          pre_next   = pretrig;
          cnt_next   = pretrig;
          state_next = (pretrig == '0) ? WAIT : PRE;
        end
      end
      PRE: begin
        if (wr_go) begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == {{(asz-1){1'b0}}, 1'b1}) begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wr_go && hit) begin
          trig_addr_next = ptr_reg;
          cnt_next       = post_cnt;
          state_next     = (post_cnt == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (wr_go) begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == {{(asz-1){1'b0}}, 1'b1}) begin
            state_next = DONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (wr_go) begin
      ptr_next = ptr_reg + 1'b1;
    end

    if (capturing && abort) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      pre_reg       <= '0;
      trig_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      pre_reg       <= pre_next;
      trig_addr_reg <= trig_addr_next;
    end
  end

  // Write port: one registered stage between the sample strobe and the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdat_reg  <= '0;
    end else begin
      wen_reg <= wr_go;
      if (wr_go) begin
        waddr_reg <= ptr_reg;
        wdat_reg  <= {in_otr, in_dat};
      end
    end
  end

  assign wen       = wen_reg;
  assign waddr     = waddr_reg;
  assign wdat      = wdat_reg;
  assign busy      = capturing;
  assign done      = (state_reg == DONE);
  assign trig_addr = trig_addr_reg;

endmodule

// File: tb/tb_adc_capture_ctl.sv
// Scoreboard bench for adc_capture_ctl: expected RAM writes are queued as
// samples are driven and matched against the registered write port.
module tb_adc_capture_ctl;

  logic        clk = 1'b0;
  logic        reset, arm, abort;
  logic [1:0]  mode;
  logic [9:0]  thresh, pretrig, in_dat;
  logic        ext_trig, in_v, in_otr;
  logic        wen, busy, done;
  logic [9:0]  waddr, trig_addr;
  logic [10:0] wdat;

  adc_capture_ctl #(.isz(10), .asz(10)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .mode(mode),
    .thresh(thresh), .pretrig(pretrig), .ext_trig(ext_trig), .in_v(in_v),
    .in_dat(in_dat), .in_otr(in_otr), .wen(wen), .waddr(waddr), .wdat(wdat),
    .busy(busy), .done(done), .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [20:0] exp_q[$];
  logic [10:0] sent[$];
  logic [10:0] ram[1024];
  int          wr_left = 0;
  logic [9:0]  exp_addr = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      ram[waddr] <= wdat;
      if (exp_q.size() == 0) begin
        check_val("unexpected_wen", {31'b0, wen}, 32'd0);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check_val("waddr", {22'b0, waddr}, {22'b0, e[20:11]});
        check_val("wdat", {21'b0, wdat}, {21'b0, e[10:0]});
      end
    end
  end

  // One input cycle; samples are expected to be written while wr_left > 0.
  task automatic cyc(input logic v, input logic [9:0] d, input logic e);
    in_v = v; in_dat = d; in_otr = d[2] ^ d[5]; ext_trig = e;
    if (v && wr_left > 0) begin
      exp_q.push_back({exp_addr, in_otr, d});
      sent.push_back({in_otr, d});
      exp_addr++;
      wr_left--;
    end
    @(posedge clk); #1;
    in_v = 1'b0; ext_trig = 1'b0;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [9:0] th, input logic [9:0] pt, input int n);
    mode = m; thresh = th; pretrig = pt; arm = 1'b1;
    exp_addr = '0; wr_left = n; sent.delete();
    @(posedge clk); #1;
    arm = 1'b0;
    check_val("busy_after_arm", {31'b0, busy}, 32'd1);
    check_val("done_after_arm", {31'b0, done}, 32'd0);
  endtask

  task automatic finish_cap(input string tag, input int trig_idx, input int pt);
    int          oa;
    logic [9:0]  oa_a, tr_a;
    check_val({tag, "_done_rise"}, {31'b0, done}, 32'd1);
    check_val({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    repeat (3) cyc(1'b1, 10'h155, 1'b1);
    check_val({tag, "_done_hold"}, {31'b0, done}, 32'd1);
    check_val({tag, "_trig_addr"}, {22'b0, trig_addr}, trig_idx % 1024);
    check_val({tag, "_drained"}, exp_q.size(), 32'd0);
    oa   = ((trig_idx - pt) % 1024 + 1024) % 1024;
    oa_a = 10'(oa);
    tr_a = 10'(trig_idx % 1024);
    check_val({tag, "_oldest"}, {21'b0, ram[oa_a]}, {21'b0, sent[sent.size() - 1024]});
    check_val({tag, "_trig_smp"}, {21'b0, ram[tr_a]}, {21'b0, sent[trig_idx]});
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; abort = 1'b0; mode = 2'd0; thresh = '0;
    pretrig = '0; ext_trig = 1'b0; in_v = 1'b0; in_dat = '0; in_otr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_wen", {31'b0, wen}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Immediate trigger, no pre-trigger, with occasional strobe gaps.
    do_arm(2'd0, 10'd0, 10'd0, 1024);
    for (int i = 0; i < 1024; i++) begin
      if (i % 97 == 5) cyc(1'b0, 10'd0, 1'b0);
      cyc(1'b1, 10'(i), 1'b0);
    end
    finish_cap("imm", 0, 0);

    // Rising threshold; pretrig changed after arm must not matter.
    do_arm(2'd1, 10'd100, 10'd256, 1423);
    pretrig = 10'd5;
    for (int j = 0; j < 256; j++) cyc(1'b1, 10'(-300 + j % 8), 1'b0);
    for (int k = 1; k <= 1167; k++) cyc(1'b1, 10'(k - 300), 1'b0);
    finish_cap("rise", 655, 256);

    // Falling threshold after a long wait that wraps the pointer.
    do_arm(2'd2, 10'd0, 10'd100, 4123);
    for (int j = 0; j < 100; j++) cyc(1'b1, 10'd50, 1'b0);
    for (int k = 1; k < 3100; k++) cyc(1'b1, 10'(1 + k % 200), 1'b0);
    cyc(1'b1, 10'(-5), 1'b0);
    for (int k = 0; k < 923; k++) cyc(1'b1, 10'(k % 300), 1'b0);
    finish_cap("fall", 3199, 100);

    // External trigger: ext_trig outside in_v and during PRE is ignored.
    do_arm(2'd3, 10'd0, 10'd4, 1074);
    for (int j = 0; j < 4; j++) cyc(1'b1, 10'(j), 1'b1);
    for (int k = 0; k < 50; k++) begin
      cyc(1'b1, 10'(k + 20), 1'b0);
      cyc(1'b0, 10'd0, 1'b1);
    end
    cyc(1'b1, 10'h1AB, 1'b1);
    for (int k = 0; k < 1019; k++) cyc(1'b1, 10'(k), 1'b1);
    finish_cap("ext", 54, 4);

    // Abort in DONE has no effect.
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    check_val("abort_done_noeff", {31'b0, done}, 32'd1);

    // Abort mid-POST.
    do_arm(2'd0, 10'd0, 10'd0, 500);
    for (int k = 0; k < 500; k++) cyc(1'b1, 10'(k * 3), 1'b0);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    check_val("abort_busy", {31'b0, busy}, 32'd0);
    check_val("abort_done", {31'b0, done}, 32'd0);
    repeat (20) cyc(1'b1, 10'h2AA, 1'b1);
    check_val("abort_nowr", exp_q.size(), 32'd0);

    // Abort together with arm: stays idle.
    mode = 2'd0; pretrig = '0; arm = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    check_val("armabort_busy", {31'b0, busy}, 32'd0);
    check_val("armabort_done", {31'b0, done}, 32'd0);
    repeat (10) cyc(1'b1, 10'h0F0, 1'b0);

    // Restart from address 0.
    do_arm(2'd0, 10'd0, 10'd0, 1024);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 10'(i ^ 10'h3C3), 1'b0);
    finish_cap("restart", 0, 0);

    // Maximum pretrig: DONE right after the trigger sample.
    do_arm(2'd1, 10'd0, 10'd1023, 1024);
    for (int j = 0; j < 1023; j++) cyc(1'b1, 10'(-10), 1'b0);
    cyc(1'b1, 10'd5, 1'b0);
    finish_cap("pt_max", 1023, 1023);

    // Reset mid-WAIT.
    do_arm(2'd1, 10'd200, 10'd0, 50);
    for (int k = 0; k < 50; k++) cyc(1'b1, 10'd7, 1'b0);
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    check_val("rst2_wen", {31'b0, wen}, 32'd0);
    check_val("rst2_waddr", {22'b0, waddr}, 32'd0);
    check_val("rst2_wdat", {21'b0, wdat}, 32'd0);
    check_val("rst2_busy", {31'b0, busy}, 32'd0);
    check_val("rst2_done", {31'b0, done}, 32'd0);
    check_val("rst2_trig_addr", {22'b0, trig_addr}, 32'd0);

    // prev must restart at 0: the first falling sample cannot trigger.
    do_arm(2'd2, 10'd0, 10'd0, 1026);
    cyc(1'b1, 10'(-3), 1'b0);
    cyc(1'b1, 10'd5, 1'b0);
    cyc(1'b1, 10'(-1), 1'b0);
    for (int k = 0; k < 1023; k++) cyc(1'b1, 10'(k), 1'b0);
    finish_cap("prev_rst", 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
